index_decoder: RTL
==================

INDEX_DECODER -- requirements
Module: index_decoder

Interface
REQ-001 The module SHALL have parameter DECODER_WIDTH, default 4, meaning the number of one-hot enable lines.
REQ-002 The module SHALL have parameter log2N, default 2, meaning the index width, with 2^log2N >= DECODER_WIDTH.
REQ-003 The module SHALL have parameter HOLD_CYCLES, default 16, meaning the number of cycles an enable line stays active; legal range 1..2^CNT_W-1.
REQ-004 The module SHALL have parameter GAP_CYCLES, default 2, meaning the number of all-zero guard cycles after activation; legal range 0..2^CNT_W-1.
REQ-005 The module SHALL have parameter CNT_W, default 8, meaning the hold/gap counter width.
REQ-006 clk  input  1  clock; all state changes on the rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 IDX_IN  input  log2N  requested enable index.
REQ-009 F_IN  input  1  index valid (found) qualifier; 0 means a null command.
REQ-010 VALID_IN  input  1  command present.
REQ-011 READY_OUT  output  1  module can accept a command.
REQ-012 ABORT  input  1  synchronous request to terminate the active phase early.
REQ-013 ONEHOT_OUT  output  DECODER_WIDTH  registered enable vector, at most one bit set.
REQ-014 BUSY  output  1  high in ACTIVE or GAP.
REQ-015 DONE  output  1  one-cycle completion pulse.
REQ-016 ERR  output  1  one-cycle pulse flagging an out-of-range index.

Function
REQ-017 The FSM SHALL have the states IDLE, ACTIVE and GAP.
REQ-018 READY_OUT SHALL be 1 exactly when the state is IDLE.
REQ-019 A command SHALL be accepted on the rising edge where VALID_IN=1 and READY_OUT=1; IDX_IN and F_IN are captured on that edge.
REQ-020 VALID_IN SHALL be ignored while READY_OUT=0, with no capture and no queueing.
REQ-021 If a command is accepted at edge k with F_IN=1 and IDX_IN<DECODER_WIDTH, the state SHALL go to ACTIVE and ONEHOT_OUT SHALL equal 1<<IDX on cycles k+1..k+HOLD_CYCLES.
REQ-022 After HOLD_CYCLES ACTIVE cycles, the state SHALL go to GAP, with ONEHOT_OUT=0 for GAP_CYCLES cycles.
REQ-023 If GAP_CYCLES=0, the GAP state SHALL be skipped.
REQ-024 On return to IDLE, DONE SHALL be 1 for exactly one cycle, coincident with READY_OUT returning to 1, i.e. at cycle k+HOLD_CYCLES+GAP_CYCLES+1.
REQ-025 If a command is accepted with F_IN=0, the state SHALL remain IDLE, ONEHOT_OUT SHALL stay 0, and DONE SHALL pulse on the next cycle.
REQ-026 Back-to-back null commands SHALL be accepted every cycle.
REQ-027 If a command is accepted with F_IN=1 and IDX_IN>=DECODER_WIDTH, the state SHALL remain IDLE, ONEHOT_OUT SHALL stay 0, and ERR and DONE SHALL both pulse on the next cycle.
REQ-028 When ABORT=1 in ACTIVE, ONEHOT_OUT SHALL be 0 on the next cycle and the state SHALL enter GAP with a full GAP_CYCLES count; if GAP_CYCLES=0, the state SHALL go to IDLE with DONE.
REQ-029 ABORT SHALL be ignored in IDLE and GAP.
REQ-030 ABORT asserted on the final ACTIVE cycle SHALL give the same result as normal expiry.
REQ-031 ONEHOT_OUT SHALL be driven only from flops, never glitching and never having more than one bit set.
REQ-032 A switch between enable lines SHALL always pass through at least GAP_CYCLES cycles of all-zero output.
REQ-033 The counter SHALL load HOLD_CYCLES-1 on entry to ACTIVE and GAP_CYCLES-1 on entry to GAP, and decrement to 0 with no wrap.
REQ-034 BUSY SHALL equal (state != IDLE), registered.

Reset
REQ-035 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, ONEHOT_OUT=0, BUSY=0, DONE=0, ERR=0, counter=0, and the captured index and F to 0.
REQ-036 READY_OUT SHALL be 1 while in reset and after reset.
REQ-037 Reset asserted mid-ACTIVE or mid-GAP SHALL drop the enables at once and produce no DONE.
REQ-038 The first edge after deassertion SHALL accept a command if VALID_IN=1.

Verification (DECODER_WIDTH=4, log2N=2, HOLD_CYCLES=4, GAP_CYCLES=2 unless stated)
REQ-039 The bench SHALL cover: accept IDX=2, F=1 at edge k -> ONEHOT=0100 on k+1..k+4, 0000 on k+5..k+6, DONE=1 and READY=1 at k+7, BUSY=1 on k+1..k+6.
REQ-040 The bench SHALL cover: IDX=3 accepted, VALID_IN held high with IDX=1 -> IDX=1 accepted at k+7, ONEHOT=1000 then 0000 for 2 cycles then 0010 from k+8, never both bits set.
REQ-041 The bench SHALL cover: F=0 commands on 3 consecutive edges -> 3 DONE pulses, ONEHOT stays 0000, READY stays 1.
REQ-042 The bench SHALL cover: with DECODER_WIDTH=5, log2N=3, accept IDX=6, F=1 -> ERR=1 and DONE=1 for one cycle, ONEHOT=00000, no BUSY.
REQ-043 The bench SHALL cover: ABORT=1 on the second ACTIVE cycle of IDX=0 -> ONEHOT=0000 next cycle, 2 GAP cycles, then DONE.
REQ-044 The bench SHALL cover: rst_n pulled low between clock edges during ACTIVE with IDX=1 -> ONEHOT=0000 before the next edge, no DONE, READY=1.

Source files
------------

// File: rtl/index_decoder.sv
// index_decoder
//   Turns an accepted index command into a timed one-hot enable pulse.
//   An accepted in-range index drives its enable line for HOLD_CYCLES
//   cycles. An all-zero guard window of GAP_CYCLES cycles follows. DONE
//   then pulses as the block becomes ready again. Null commands (F_IN=0)
//   and out-of-range indices complete at once without touching the
//   enables. Out-of-range indices also raise ERR.
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   IDX_IN      requested enable index
//   F_IN        index-valid qualifier (0 = null command)
//   VALID_IN    command present
//   READY_OUT   high while idle; a command is taken when VALID_IN is also high
//   ABORT       ends the active phase early
//   ONEHOT_OUT  registered one-hot enable vector
//   BUSY        high while in ACTIVE or GAP
//   DONE        one-cycle completion pulse
//   ERR         one-cycle out-of-range pulse
module index_decoder #(
  parameter int DECODER_WIDTH = 4,
  parameter int log2N         = 2,
  parameter int HOLD_CYCLES   = 16,
  parameter int GAP_CYCLES    = 2,
  parameter int CNT_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [log2N-1:0]         IDX_IN,
  input  logic                     F_IN,
  input  logic                     VALID_IN,
  output logic                     READY_OUT,
  input  logic                     ABORT,
  output logic [DECODER_WIDTH-1:0] ONEHOT_OUT,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR
);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic [log2N-1:0]         r_idx;
  logic                     r_f;
  logic [DECODER_WIDTH-1:0] r_onehot;
  logic [DECODER_WIDTH-1:0] w_onehot_nxt;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_err;
  logic                     w_done_nxt;
  logic                     w_err_nxt;
  logic                     w_accept;
  logic                     w_in_range;
  logic                     w_cnt_zero;

  assign READY_OUT  = (r_state == IDLE);
  assign w_accept   = VALID_IN && READY_OUT;
  assign w_in_range = (int'(IDX_IN) < DECODER_WIDTH);
  assign w_cnt_zero = (r_cnt == '0);

  assign ONEHOT_OUT = r_onehot;
  assign BUSY       = r_busy;
  assign DONE       = r_done;
  assign ERR        = r_err;

  // State, counter, captured command and all outputs are flops.
  // Reset clears everything at once, so enables drop without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_f      <= 1'b0;
      r_onehot <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_onehot <= w_onehot_nxt;
      r_busy   <= (w_state_nxt != IDLE);
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      if (w_accept) begin
        r_idx <= IDX_IN;
        r_f   <= F_IN;
      end
    end
  end

  // Next-state logic.
  // An abort on the last active cycle coincides with normal expiry.
  // Both cases take the same path.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept && F_IN && w_in_range) begin
          w_state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (w_cnt_zero || ABORT) begin
          w_state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (w_cnt_zero) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the counter and the registered outputs.
  // The enable vector is zero everywhere except while staying in ACTIVE.
  // That guarantees a zero window between two different enable lines.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_onehot_nxt = '0;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (F_IN && w_in_range) begin
            w_cnt_nxt    = HOLD_LOAD;
            w_onehot_nxt = DECODER_WIDTH'(1) << IDX_IN;
          end else begin
            w_done_nxt = 1'b1;
            w_err_nxt  = F_IN;
          end
        end
      end
      ACTIVE: begin
        if (w_cnt_zero || ABORT) begin
          if (GAP_CYCLES > 0) begin
            w_cnt_nxt = GAP_LOAD;
          end else begin
            w_cnt_nxt  = '0;
            w_done_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt    = r_cnt - 1'b1;
          w_onehot_nxt = r_f ? (DECODER_WIDTH'(1) << r_idx) : '0;
        end
      end
      GAP: begin
        if (w_cnt_zero) begin
          w_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_cnt_nxt = '0;
      end
    endcase
  end

endmodule
